// File: rtl/uart_tx_readback.sv
// rtl/uart_tx_readback.sv - reads N delay-RAM entries and sends each as an 8-byte UART frame on txb.
// Optional even parity bit per byte when UART_TX_PARITY_EN is defined (8E1 instead of 8N1).
module uart_tx_readback #(
  parameter int CLKS_PER_BIT = 87,
  parameter int RD_LATENCY   = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic        I_clk_10M,
  input  logic        I_rst,
  input  logic [4:0]  I_GA,
  input  logic        I_rd_req,
  input  logic [1:0]  I_rd_port,
  input  logic [10:0] I_rd_start_addr,
  input  logic [10:0] I_rd_count,
  output logic        O_RD_EN,
  output logic [10:0] O_READ_ADDR,
  input  logic [23:0] I_READ_DELAY_RAM1,
  input  logic [23:0] I_READ_DELAY_RAM2,
  input  logic [23:0] I_READ_DELAY_RAM3,
  input  logic [23:0] I_READ_DELAY_RAM4,
  output logic        O_rd_busy,
  output logic        O_rd_done,
  output logic        txb
);

`ifdef UART_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  // Bit index 0 is the start bit, so the last stop bit sits at 8+parity+stop.
  localparam logic [3:0] BIT_LAST  = 4'(8 + PAR_BITS + STOP_BITS);
  localparam logic [1:0] WAIT_LAST = 2'(RD_LATENCY - 1);

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, LOAD, SHIFT, NEXT} state_t;

  state_t             state_q, state_d;
  logic [4:0]         ga_q, ga_d;
  logic [1:0]         port_q, port_d;
  logic [10:0]        addr_q, addr_d;
  logic [10:0]        count_q, count_d;
  logic [1:0]         wait_q, wait_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic [3:0]         bit_q, bit_d;
  logic [2:0]         byte_q, byte_d;
  logic [63:0]        frame_q, frame_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               txb_q, txb_d;

  logic [23:0]        ram_data;
  logic [7:0]         b1, b2;
  logic [63:0]        new_frame;

  function automatic logic bit_val(input logic [7:0] b, input logic [3:0] idx);
    logic [2:0] di;
    di = 3'(idx - 4'd1);
    if (idx == 4'd0) return 1'b0;
    if (idx <= 4'd8) return b[di];
    if (PAR_BITS == 1 && idx == 4'd9) return ^b;
    return 1'b1;
  endfunction

  always_comb begin
    case (port_q)
      2'd0:    ram_data = I_READ_DELAY_RAM1;
      2'd1:    ram_data = I_READ_DELAY_RAM2;
      2'd2:    ram_data = I_READ_DELAY_RAM3;
      default: ram_data = I_READ_DELAY_RAM4;
    endcase
    b1 = {1'b0, ga_q, port_q};
    b2 = {5'b0, addr_q[10:8]};
    new_frame = {b1 ^ b2 ^ addr_q[7:0] ^ ram_data[23:16] ^ ram_data[15:8] ^ ram_data[7:0],
                 ram_data[7:0], ram_data[15:8], ram_data[23:16],
                 addr_q[7:0], b2, b1, 8'hA5};
  end

  always_comb begin
    state_d = state_q;
    ga_d    = ga_q;
    port_d  = port_q;
    addr_d  = addr_q;
    count_d = count_q;
    wait_d  = wait_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    frame_d = frame_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    txb_d   = txb_q;
    case (state_q)
      IDLE: begin
        txb_d = 1'b1;
        // done_q guard keeps a request in a zero-count completion cycle from being taken.
        if (I_rd_req && !done_q) begin
          ga_d    = I_GA;
          port_d  = I_rd_port;
          addr_d  = I_rd_start_addr;
          count_d = I_rd_count;
          if (I_rd_count == 11'd0) begin
            done_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            state_d = RD_ISSUE;
          end
        end
      end
      RD_ISSUE: begin
        wait_d  = 2'd0;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          state_d = LOAD;
          baud_d  = '0;
          bit_d   = 4'd0;
          byte_d  = 3'd0;
          txb_d   = 1'b0;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      LOAD, SHIFT: begin
        if (state_q == LOAD) frame_d = new_frame;
        state_d = SHIFT;
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) begin
            bit_d = 4'd0;
            if (byte_q == 3'd7) begin
              state_d = NEXT;
              if (count_q == 11'd1) begin
                done_d = 1'b1;
                busy_d = 1'b0;
              end
            end else begin
              byte_d = byte_q + 3'd1;
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
        txb_d = (state_d == NEXT) ? 1'b1 : bit_val(frame_d[{byte_d, 3'b000} +: 8], bit_d);
      end
      NEXT: begin
        count_d = count_q - 11'd1;
        addr_d  = addr_q + 11'd1;
        txb_d   = 1'b1;
        state_d = (count_q == 11'd1) ? IDLE : RD_ISSUE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge I_clk_10M or posedge I_rst) begin
    if (I_rst) begin
      state_q <= IDLE;
      ga_q    <= '0;
      port_q  <= '0;
      addr_q  <= '0;
      count_q <= '0;
      wait_q  <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      frame_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      txb_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      ga_q    <= ga_d;
      port_q  <= port_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      wait_q  <= wait_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      frame_q <= frame_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      txb_q   <= txb_d;
    end
  end

  assign O_RD_EN     = (state_q == RD_ISSUE);
  assign O_READ_ADDR = addr_q;
  assign O_rd_busy   = busy_q;
  assign O_rd_done   = done_q;
  assign txb         = txb_q;

endmodule

// File: tb/tb_uart_tx_readback.sv
// tb/tb_uart_tx_readback.sv - vector table plus random requests checked by a UART receiver and frame model.
module tb_uart_tx_readback;
  localparam int CPB = 87;
  localparam int LAT = 1;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FR  = 8 * NB * CPB;
  localparam int GAP = 2 + LAT;

  logic        clk = 1'b0;
  logic        I_rst;
  logic [4:0]  I_GA;
  logic        I_rd_req;
  logic [1:0]  I_rd_port;
  logic [10:0] I_rd_start_addr;
  logic [10:0] I_rd_count;
  logic        O_RD_EN;
  logic [10:0] O_READ_ADDR;
  logic [23:0] ram_q [4];
  logic        O_rd_busy;
  logic        O_rd_done;
  logic        txb;

  uart_tx_readback #(.CLKS_PER_BIT(CPB), .RD_LATENCY(LAT), .STOP_BITS(1)) dut (
    .I_clk_10M(clk), .I_rst(I_rst), .I_GA(I_GA), .I_rd_req(I_rd_req),
    .I_rd_port(I_rd_port), .I_rd_start_addr(I_rd_start_addr), .I_rd_count(I_rd_count),
    .O_RD_EN(O_RD_EN), .O_READ_ADDR(O_READ_ADDR),
    .I_READ_DELAY_RAM1(ram_q[0]), .I_READ_DELAY_RAM2(ram_q[1]),
    .I_READ_DELAY_RAM3(ram_q[2]), .I_READ_DELAY_RAM4(ram_q[3]),
    .O_rd_busy(O_rd_busy), .O_rd_done(O_rd_done), .txb(txb)
  );

  always #50 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [23:0] mem [4][2048];
  always @(posedge clk) begin
    if (O_RD_EN === 1'b1) begin
      for (int p = 0; p < 4; p++) ram_q[p] <= mem[p][O_READ_ADDR];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    int         start;
    bit         ok;
  } rx_t;
  rx_t         rx_q[$];
  logic [10:0] addr_q[$];
  bit          rx_en = 1'b1;

  always @(negedge clk) begin
    if (rx_en && O_RD_EN === 1'b1) addr_q.push_back(O_READ_ADDR);
  end

  // Mid-bit sampling UART receiver; records each byte with the cycle its start bit began.
  initial begin
    logic [7:0] d;
    int  st;
    bit  ok;
    forever begin
      @(negedge clk);
      if (rx_en && I_rst === 1'b0 && txb === 1'b0) begin
        st = cyc;
        ok = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        if (txb !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          d[i] = txb;
        end
`ifdef UART_TX_PARITY_EN
        repeat (CPB) @(negedge clk);
        if (txb !== ^d) ok = 1'b0;
`endif
        repeat (CPB) @(negedge clk);
        if (txb !== 1'b1) ok = 1'b0;
        if (rx_en) rx_q.push_back('{d, st, ok});
      end
    end
  end

  function automatic logic [7:0] frame_byte(input logic [4:0] ga, input logic [1:0] port,
                                            input logic [10:0] a, input logic [23:0] d, input int k);
    logic [7:0] b [8];
    b[0] = 8'hA5;
    b[1] = {1'b0, ga, port};
    b[2] = {5'b0, a[10:8]};
    b[3] = a[7:0];
    b[4] = d[23:16];
    b[5] = d[15:8];
    b[6] = d[7:0];
    b[7] = b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5] ^ b[6];
    return b[k];
  endfunction

  typedef struct {
    logic [4:0]  ga;
    logic [1:0]  port;
    logic [10:0] addr;
    logic [10:0] count;
    int          probe;
    int          exp_first;
    int          exp_done;
  } vec_t;
  vec_t vecs[6];

  function automatic int done_off(input int count);
    return (count == 0) ? 1 : GAP + (count - 1) * (FR + GAP) + FR;
  endfunction

  task automatic run_vec(input vec_t v);
    int n, done_cyc, cnt;
    logic [10:0] a;
    cnt = int'(v.count);
    rx_q.delete();
    addr_q.delete();
    @(negedge clk);
    n = cyc;
    I_GA = v.ga; I_rd_port = v.port; I_rd_start_addr = v.addr; I_rd_count = v.count;
    I_rd_req = 1'b1;
    @(negedge clk);
    I_rd_req = 1'b0;
    done_cyc = -1;
    if (cnt == 0) begin
      chk("zero_done", O_rd_done, 1);
      chk("zero_busy", O_rd_busy, 0);
      repeat (2 * CPB) @(negedge clk);
      chk("zero_rx_bytes", rx_q.size(), 0);
      chk("zero_rd_en", addr_q.size(), 0);
      return;
    end
    chk("busy_after_req", O_rd_busy, 1);
    while (done_cyc < 0 && cyc <= n + v.exp_done + 50) begin
      if (O_rd_done === 1'b1) done_cyc = cyc;
      else begin
        @(negedge clk);
        I_rd_req = 1'b0;
        if (v.probe == 1 && cyc == n + 15 * CPB) begin
          I_rd_start_addr = v.addr + 11'd100; I_rd_count = 11'd3; I_rd_req = 1'b1;
        end
      end
    end
    chk("done_seen", done_cyc >= 0, 1);
    chk("done_latency", done_cyc - n, v.exp_done);
    chk("busy_at_done", O_rd_busy, 0);
    if (v.probe == 2) begin
      I_rd_start_addr = 11'd7; I_rd_count = 11'd1; I_rd_req = 1'b1;
      @(negedge clk);
      I_rd_req = 1'b0;
      chk("req_at_done_busy", O_rd_busy, 0);
      chk("req_at_done_pulse", O_rd_done, 0);
    end
    repeat (6) @(negedge clk);
    chk("rx_byte_count", rx_q.size(), 8 * cnt);
    chk("rd_en_count", addr_q.size(), cnt);
    for (int f = 0; f < cnt; f++) begin
      a = 11'((int'(v.addr) + f) % 2048);
      if (f < addr_q.size()) chk("read_addr", addr_q[f], a);
      for (int k = 0; k < 8; k++) begin
        if (8 * f + k < rx_q.size()) begin
          chk("rx_byte", rx_q[8*f+k].data, frame_byte(v.ga, v.port, a, mem[v.port][a], k));
          chk("rx_start_cycle", rx_q[8*f+k].start - n, v.exp_first + f * (FR + GAP) + k * NB * CPB);
          chk("rx_framing", rx_q[8*f+k].ok, 1);
        end
      end
    end
  endtask

  initial begin
    int n;
    for (int p = 0; p < 4; p++)
      for (int i = 0; i < 2048; i++) mem[p][i] = 24'($urandom);
    mem[2][11'h123] = 24'hABCDEF;
    for (int p = 0; p < 4; p++) ram_q[p] = '0;

    vecs[0] = '{5'h03, 2'd2, 11'h123, 11'd1, 0, 0, 0};
    vecs[1] = '{5'h11, 2'd1, 11'd2046, 11'd3, 2, 0, 0};
    vecs[2] = '{5'h07, 2'd0, 11'h055, 11'd0, 0, 0, 0};
    vecs[3] = '{5'h1F, 2'd3, 11'h2A0, 11'd2, 1, 0, 0};
    vecs[4] = '{5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 11'($urandom_range(0, 2047)), 11'd1, 0, 0, 0};
    vecs[5] = '{5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 11'd2047, 11'd1, 0, 0, 0};
    for (int i = 0; i < 6; i++) begin
      vecs[i].exp_first = GAP;
      vecs[i].exp_done  = done_off(int'(vecs[i].count));
    end

    I_rst = 1'b1; I_GA = '0; I_rd_req = 1'b0; I_rd_port = '0; I_rd_start_addr = '0; I_rd_count = '0;
    repeat (3) @(negedge clk);
    chk("rst_txb", txb, 1);
    chk("rst_rd_en", O_RD_EN, 0);
    chk("rst_read_addr", O_READ_ADDR, 0);
    chk("rst_busy", O_rd_busy, 0);
    chk("rst_done", O_rd_done, 0);
    I_rst = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of the first byte, while a data bit is on the line.
    n = cyc;
    I_GA = 5'h01; I_rd_port = 2'd0; I_rd_start_addr = 11'd5; I_rd_count = 11'd1; I_rd_req = 1'b1;
    @(negedge clk);
    I_rd_req = 1'b0;
    while (cyc < n + GAP + 4 * CPB + 7) @(negedge clk);
    rx_en = 1'b0;
    chk("midframe_busy", O_rd_busy, 1);
    I_rst = 1'b1;
    #1;
    chk("midrst_txb", txb, 1);
    chk("midrst_busy", O_rd_busy, 0);
    chk("midrst_rd_en", O_RD_EN, 0);
    chk("midrst_read_addr", O_READ_ADDR, 0);
    @(negedge clk);
    I_rst = 1'b0;
    repeat (NB * CPB + 5) @(negedge clk);
    chk("post_rst_txb", txb, 1);
    rx_q.delete();
    addr_q.delete();
    rx_en = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i]);
      repeat (10) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
